// File: rtl/m_wbuart_ctrl.sv
// Wishbone-slave 8N1 UART: programmable baud divisor, 1-deep TX holding register and
// 1-deep RX buffer, level interrupt for RX-ready / TX-holding-empty.
module m_wbuart_ctrl #(
  parameter int unsigned DIVWIDTH   = 16,
  parameter int unsigned DEFAULTDIV = 104
) (
  input  logic        CLK_I,
  input  logic        RST_I_n,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [3:0]  SEL_I,
  input  logic [1:0]  ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  input  logic        usartRX,
  output logic        usartTX,
  output logic        irq
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  localparam logic [DIVWIDTH-1:0] MinPer = DIVWIDTH'(4);
  localparam logic [DIVWIDTH-1:0] One    = DIVWIDTH'(1);

  // Bus decode
  logic wr_data, wr_stat_lo, wr_stat_hi, wr_div, rd_data;

  assign ACK_O      = STB_I;
  assign wr_data    = STB_I & WE_I & (ADR_I == 2'd0) & SEL_I[0];
  assign wr_stat_lo = STB_I & WE_I & (ADR_I == 2'd1) & SEL_I[0];
  assign wr_stat_hi = STB_I & WE_I & (ADR_I == 2'd1) & SEL_I[1];
  assign wr_div     = STB_I & WE_I & (ADR_I == 2'd2);
  assign rd_data    = STB_I & ~WE_I & (ADR_I == 2'd0);

  logic unused_bits;
  assign unused_bits = ^{SEL_I[3:2], DAT_I};

  // Control registers
  logic [DIVWIDTH-1:0] div_q, per, half, div_wmask;
  logic                rxie_q, txie_q;

  // Divisors below 4 would leave no room for the mid-bit RX sample.
  assign per  = (div_q < MinPer) ? MinPer : div_q;
  assign half = per >> 1;

  always_comb begin
    div_wmask = '0;
    for (int i = 0; i < DIVWIDTH; i++) begin
      if (i < 8) begin
        div_wmask[i] = SEL_I[0];
      end else if (i < 16) begin
        div_wmask[i] = SEL_I[1];
      end
    end
  end

  // TX path
  state_e              tx_state_q;
  logic [DIVWIDTH-1:0] tx_cnt_q;
  logic [2:0]          tx_bit_q;
  logic [7:0]          tx_shift_q, thr_q;
  logic                txfull_q, tx_load, thr_accept, tx_tick, txbusy;

  assign tx_tick    = (tx_cnt_q == '0);
  // Holding register drains from IDLE or straight out of a finished stop bit.
  assign tx_load    = txfull_q & ((tx_state_q == StIdle) | ((tx_state_q == StStop) & tx_tick));
  assign thr_accept = wr_data & (~txfull_q | tx_load);
  assign txbusy     = (tx_state_q != StIdle) | txfull_q;

  always_ff @(posedge CLK_I) begin
    if (!RST_I_n) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      thr_q      <= '0;
      txfull_q   <= 1'b0;
      usartTX    <= 1'b1;
    end else begin
      if (thr_accept) begin
        thr_q    <= DAT_I[7:0];
        txfull_q <= 1'b1;
      end else if (tx_load) begin
        txfull_q <= 1'b0;
      end

      if (tx_load) begin
        tx_shift_q <= thr_q;
        tx_state_q <= StStart;
        tx_cnt_q   <= per - One;
        usartTX    <= 1'b0;
      end else begin
        case (tx_state_q)
          StIdle: usartTX <= 1'b1;
          StStart: begin
            if (tx_tick) begin
              tx_state_q <= StData;
              tx_cnt_q   <= per - One;
              tx_bit_q   <= '0;
              usartTX    <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
            end else begin
              tx_cnt_q <= tx_cnt_q - One;
            end
          end
          StData: begin
            if (tx_tick) begin
              tx_cnt_q <= per - One;
              if (tx_bit_q == 3'd7) begin
                tx_state_q <= StStop;
                usartTX    <= 1'b1;
              end else begin
                tx_bit_q   <= tx_bit_q + 3'd1;
                usartTX    <= tx_shift_q[0];
                tx_shift_q <= tx_shift_q >> 1;
              end
            end else begin
              tx_cnt_q <= tx_cnt_q - One;
            end
          end
          StStop: begin
            if (tx_tick) begin
              tx_state_q <= StIdle;
            end else begin
              tx_cnt_q <= tx_cnt_q - One;
            end
          end
          default: tx_state_q <= StIdle;
        endcase
      end
    end
  end

  // RX path
  state_e              rx_state_q;
  logic [DIVWIDTH-1:0] rx_cnt_q;
  logic [2:0]          rx_bit_q;
  logic [7:0]          rx_shift_q, rxdata_q;
  logic                rx_s1_q, rx_s2_q, rx_d_q, rx_tick;
  logic                rxvalid_q, overrun_q, frameerr_q;

  assign rx_tick = (rx_cnt_q == '0);

  always_ff @(posedge CLK_I) begin
    if (!RST_I_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_d_q     <= 1'b1;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rxdata_q   <= '0;
      rxvalid_q  <= 1'b0;
      overrun_q  <= 1'b0;
      frameerr_q <= 1'b0;
    end else begin
      rx_s1_q <= usartRX;
      rx_s2_q <= rx_s1_q;
      rx_d_q  <= rx_s2_q;

      if (rd_data) rxvalid_q <= 1'b0;
      if (wr_stat_lo && DAT_I[3]) overrun_q <= 1'b0;
      if (wr_stat_lo && DAT_I[4]) frameerr_q <= 1'b0;

      // Flag updates below come later, so a set beats a same-cycle clear.
      case (rx_state_q)
        StIdle: begin
          if (rx_d_q && !rx_s2_q) begin
            rx_state_q <= StStart;
            rx_cnt_q   <= half - One;
          end
        end
        StStart: begin
          if (rx_tick) begin
            if (rx_s2_q) begin
              rx_state_q <= StIdle;
            end else begin
              rx_state_q <= StData;
              rx_cnt_q   <= per - One;
              rx_bit_q   <= '0;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - One;
          end
        end
        StData: begin
          if (rx_tick) begin
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            rx_cnt_q   <= per - One;
            if (rx_bit_q == 3'd7) rx_state_q <= StStop;
          end else begin
            rx_cnt_q <= rx_cnt_q - One;
          end
        end
        StStop: begin
          if (rx_tick) begin
            rx_state_q <= StIdle;
            if (!rx_s2_q) begin
              frameerr_q <= 1'b1;
            end else if (rxvalid_q) begin
              overrun_q <= 1'b1;
            end else begin
              rxdata_q  <= rx_shift_q;
              rxvalid_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - One;
          end
        end
        default: rx_state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I_n) begin
      div_q  <= DIVWIDTH'(DEFAULTDIV);
      rxie_q <= 1'b0;
      txie_q <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_div) div_q <= (div_q & ~div_wmask) | (DAT_I[DIVWIDTH-1:0] & div_wmask);
      if (wr_stat_hi) begin
        rxie_q <= DAT_I[8];
        txie_q <= DAT_I[9];
      end
      irq <= (rxie_q & rxvalid_q) | (txie_q & ~txfull_q);
    end
  end

  logic [31:0] status;
  assign status = {22'd0, txie_q, rxie_q, 3'd0, frameerr_q, overrun_q, rxvalid_q, txfull_q, txbusy};

  always_comb begin
    DAT_O = '0;
    if (STB_I) begin
      case (ADR_I)
        2'd0:    DAT_O = {24'd0, rxdata_q};
        2'd1:    DAT_O = status;
        2'd2:    DAT_O = 32'(div_q);
        default: DAT_O = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_m_wbuart_ctrl.sv
// Bench for m_wbuart_ctrl: directed and randomized TX/RX frames checked against a
// frame-level reference model of the status flags and serial waveform.
module tb_m_wbuart_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [1:0]  adr = 2'd0;
  logic [31:0] wdat = 32'd0;
  logic [31:0] rdat;
  logic        ack;
  logic        rx = 1'b1;
  logic        tx;
  logic        irq;
  logic        irq_at_rd = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: frame-level view of the programmer-visible state
  bit         m_valid, m_over, m_ferr, m_rxie, m_txie;
  logic [7:0] m_data;

  m_wbuart_ctrl #(.DIVWIDTH(16), .DEFAULTDIV(104)) dut (
    .CLK_I   (clk),
    .RST_I_n (rst_n),
    .STB_I   (stb),
    .WE_I    (we),
    .SEL_I   (sel),
    .ADR_I   (adr),
    .DAT_I   (wdat),
    .DAT_O   (rdat),
    .ACK_O   (ack),
    .usartRX (rx),
    .usartTX (tx),
    .irq     (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus(input bit w, input logic [1:0] a, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] q);
    @(negedge clk);
    stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    #1;
    q = rdat;
    irq_at_rd = irq;
    @(posedge clk);
    #1;
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] dummy;
    bus(1'b1, a, s, d, dummy);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] q);
    bus(1'b0, a, 4'hF, 32'd0, q);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one 8N1 frame at p clocks per bit, then idles long enough for the stop sample.
  task automatic rx_frame(input logic [7:0] b, input bit stopb, input int p);
    logic [9:0] fb;
    fb = {stopb, b, 1'b0};
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      rx = fb[i];
      repeat (p) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    repeat (p + 4) @(posedge clk);
    #1;
  endtask

  function automatic void rx_model(input logic [7:0] b, input bit stopb);
    if (!stopb) m_ferr = 1'b1;
    else if (m_valid) m_over = 1'b1;
    else begin
      m_data  = b;
      m_valid = 1'b1;
    end
  endfunction

  // Status as seen with the transmitter idle
  function automatic logic [31:0] exp_status();
    return {22'd0, m_txie, m_rxie, 3'd0, m_ferr, m_over, m_valid, 2'b00};
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] q;
    logic [31:0] clr;
    logic [9:0]  bits;
    logic [19:0] bits2;
    logic [7:0]  b;
    bit          stopb, found;
    int          w, t0, p, pdiv, lows;

    m_valid = 0; m_over = 0; m_ferr = 0; m_rxie = 0; m_txie = 0; m_data = 8'h00;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check("rst_tx", tx, 1);
    check("rst_irq", irq, 0);
    check("idle_ack", ack, 0);
    check("idle_dat", rdat, 0);
    rd(2'd1, q); check("rst_status", q, exp_status());
    rd(2'd2, q); check("rst_div", q, 104);
    rd(2'd3, q); check("adr3_read", q, 0);

    // 0x55 at the default divisor
    wr(2'd0, 4'h1, 32'h55);
    w = cyc;
    check("t1_pre_start", tx, 1);
    wait_cyc(w + 1);
    check("t1_start_edge", tx, 0);
    t0 = w + 1;
    bits = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 10; k++) begin
      wait_cyc(t0 + k * 104 + 52);
      check($sformatf("t1_bit%0d", k), tx, bits[k]);
      rd(2'd1, q);
      check($sformatf("t1_busy%0d", k), q[0], 1);
    end
    wait_cyc(t0 + 1040);
    rd(2'd1, q); check("t1_done_status", q, exp_status());

    // Divisor byte-lane gating
    wr(2'd2, 4'h3, 32'd4);
    wr(2'd2, 4'h1, 32'hABCD);
    rd(2'd2, q); check("div_sel0", q, 32'h00CD);
    wr(2'd2, 4'h2, 32'h1200);
    rd(2'd2, q); check("div_sel1", q, 32'h12CD);

    // Back-to-back writes at P=4: two contiguous frames, third write dropped
    wr(2'd2, 4'h3, 32'd4);
    wr(2'd0, 4'h1, 32'hA3);
    w = cyc;
    wr(2'd0, 4'h1, 32'h0F);
    wr(2'd0, 4'h1, 32'h1E);
    rd(2'd1, q); check("t2_txfull", q[1], 1);
    t0 = w + 1;
    bits2 = {1'b1, 8'h0F, 1'b0, 1'b1, 8'hA3, 1'b0};
    for (int k = 0; k < 20; k++) begin
      wait_cyc(t0 + k * 4 + 2);
      check($sformatf("t2_bit%0d", k), tx, bits2[k]);
    end
    lows = 0;
    for (int k = 0; k < 24; k++) begin
      wait_cyc(t0 + 80 + k);
      if (!tx) lows++;
    end
    check("t2_no_third_frame", lows, 0);
    rd(2'd1, q); check("t2_done_status", q, exp_status());

    // Randomized TX, including divisors below the minimum period
    for (int it = 0; it < 5; it++) begin
      pdiv = $urandom_range(0, 12);
      p = (pdiv < 4) ? 4 : pdiv;
      b = 8'($urandom);
      wr(2'd2, 4'h3, 32'(pdiv));
      rd(2'd2, q); check("rt_div", q, pdiv);
      wr(2'd0, 4'h1, {24'd0, b});
      w = cyc;
      t0 = w + 1;
      bits = {1'b1, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
        wait_cyc(t0 + k * p + p / 2);
        check($sformatf("rt%0d_bit%0d", it, k), tx, bits[k]);
      end
      wait_cyc(t0 + 10 * p);
      rd(2'd1, q); check("rt_status", q, exp_status());
    end

    // Directed RX at P=16
    wr(2'd2, 4'h3, 32'd16);
    rx_frame(8'hC6, 1'b1, 16); rx_model(8'hC6, 1'b1);
    rd(2'd1, q); check("rx_c6_status", q, exp_status());
    rd(2'd0, q); check("rx_c6_data", q, 32'h0000_00C6);
    m_valid = 1'b0;
    rd(2'd1, q); check("rx_c6_cleared", q, exp_status());

    rx_frame(8'h11, 1'b1, 16); rx_model(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1, 16); rx_model(8'h22, 1'b1);
    rd(2'd1, q); check("rx_overrun_status", q, exp_status());
    rd(2'd0, q); check("rx_overrun_data", q, 32'h11);
    m_valid = 1'b0;
    wr(2'd1, 4'h1, 32'h8); m_over = 1'b0;
    rd(2'd1, q); check("rx_overrun_clr", q, exp_status());

    rx_frame(8'h5A, 1'b0, 16); rx_model(8'h5A, 1'b0);
    rd(2'd1, q); check("rx_frameerr_status", q, exp_status());
    wr(2'd1, 4'h1, 32'h10); m_ferr = 1'b0;
    rd(2'd1, q); check("rx_frameerr_clr", q, exp_status());

    @(posedge clk);
    #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    rd(2'd1, q); check("rx_glitch_status", q, exp_status());
    rx_frame(8'h3C, 1'b1, 16); rx_model(8'h3C, 1'b1);
    rd(2'd0, q); check("rx_after_glitch", q, 32'h3C);
    m_valid = 1'b0;

    // Randomized RX against the model
    for (int it = 0; it < 10; it++) begin
      p = $urandom_range(6, 24);
      wr(2'd2, 4'h3, 32'(p));
      b = 8'($urandom);
      stopb = ($urandom_range(0, 3) != 0);
      rx_frame(b, stopb, p); rx_model(b, stopb);
      rd(2'd1, q); check($sformatf("rr%0d_status", it), q, exp_status());
      if ($urandom_range(0, 1) == 1) begin
        rd(2'd0, q); check($sformatf("rr%0d_data", it), q, {24'd0, m_data});
        m_valid = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) begin
        clr = $urandom & 32'h18;
        wr(2'd1, 4'h1, clr);
        if (clr[3]) m_over = 1'b0;
        if (clr[4]) m_ferr = 1'b0;
      end
    end

    // Reset in the middle of a TX data phase
    wr(2'd2, 4'h3, 32'd16);
    wr(2'd0, 4'h1, 32'h00);
    w = cyc;
    t0 = w + 1;
    wait_cyc(t0 + 3 * 16 + 8);
    check("mid_tx_low", tx, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_valid = 0; m_over = 0; m_ferr = 0; m_rxie = 0; m_txie = 0;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_irq", irq, 0);
    rd(2'd1, q); check("mid_rst_status", q, exp_status());
    rd(2'd2, q); check("mid_rst_div", q, 104);

    // RX interrupt latency
    wr(2'd2, 4'h3, 32'd16);
    wr(2'd1, 4'h2, 32'h100); m_rxie = 1'b1;
    rd(2'd1, q); check("rxie_status", q, exp_status());
    check("rxie_irq_idle", irq, 0);
    found = 1'b0;
    fork
      rx_frame(8'h96, 1'b1, 16);
      begin
        for (int n = 0; n < 400 && !found; n++) begin
          rd(2'd1, q);
          if (q[2]) begin
            found = 1'b1;
            check("irq_same_cycle", irq_at_rd, 0);
            check("irq_next_cycle", irq, 1);
          end
        end
      end
    join
    check("rxvalid_seen", found, 1);
    rx_model(8'h96, 1'b1);
    rd(2'd0, q); check("irq_rx_data", q, 32'h96);
    m_valid = 1'b0;

    // TX-empty interrupt
    wr(2'd1, 4'h2, 32'h300); m_txie = 1'b1;
    rd(2'd1, q); check("txie_status", q, exp_status());
    @(posedge clk);
    #1;
    check("txie_irq", irq, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
